// File: rtl/display_scanner_if.sv
// Bus between a display_scanner and its controller: value load strobe in, scan outputs out.
// No latency of its own; the load strobe is always accepted, so there is no backpressure.
// master: the side that loads values; slave: the scanner itself.
interface display_scanner_if;
    logic        load;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [3:0]  nibble;
    logic [7:0]  digitselect;
    logic        pending;

    modport master (
        output load, value, digit_en,
        input  nibble, digitselect, pending
    );

    modport slave (
        input  load, value, digit_en,
        output nibble, digitselect, pending
    );
endinterface

// File: rtl/display_scanner.sv
// Eight-digit seven-segment scan driver with a frame-boundary double buffer (LEADING_ZERO_BLANK_EN optional).
// Load reaches the display after 1 to 8*2^DIV_BITS cycles; outputs come from registered state only.
// No backpressure: a load is always taken, and it overwrites any value still waiting for commit.
module display_scanner #(
    parameter int DIV_BITS = 17
) (
    input  logic           clk,
    input  logic           reset_n,
    display_scanner_if.slave bus
);

    localparam logic [DIV_BITS-1:0] CNT_ONE = DIV_BITS'(1);

    logic [DIV_BITS-1:0] cnt;
    logic [2:0]          idx;
    logic [31:0]         disp_val;
    logic [7:0]          disp_en;
    logic [31:0]         pend_val;
    logic [7:0]          pend_en;
    logic                pend_flag;

    logic tick;
    logic commit;
    logic lit;

    assign tick   = &cnt;
    assign commit = tick && (idx == 3'd7) && pend_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            idx       <= 3'd0;
            disp_val  <= 32'd0;
            disp_en   <= 8'hFF;
            pend_val  <= 32'd0;
            pend_en   <= 8'd0;
            pend_flag <= 1'b0;
        end else begin
            cnt <= cnt + CNT_ONE;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            // Commit reads the pending buffer before a same-cycle load replaces it.
            if (commit) begin
                disp_val <= pend_val;
                disp_en  <= pend_en;
            end
            if (bus.load) begin
                pend_val  <= bus.value;
                pend_en   <= bus.digit_en;
                pend_flag <= 1'b1;
            end else if (commit) begin
                pend_flag <= 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] blank;

    // Digit i goes dark when it and every digit to its left hold zero.
    always_comb begin
        blank = 8'd0;
        for (int i = 1; i < 8; i++) begin
            blank[i] = ((disp_val >> (4 * i)) == 32'd0);
        end
    end

    assign lit = disp_en[idx] & ~blank[idx];
`else
    assign lit = disp_en[idx];
`endif

    assign bus.nibble      = disp_val[{idx, 2'b00} +: 4];
    assign bus.digitselect = lit ? ~(8'h01 << idx) : 8'hFF;
    assign bus.pending     = pend_flag;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner at DIV_BITS=2: frame-position model plus hand-computed literal checks.
module tb_display_scanner;

    localparam int DIV   = 2;
    localparam int DIGIT = 1 << DIV;
    localparam int FRAME = 8 * DIGIT;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    display_scanner_if bus ();

    display_scanner #(.DIV_BITS(DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: edges since reset, value shown, value waiting, all in frame-position terms.
    int          cyc;
    logic [31:0] m_val;
    logic [7:0]  m_en;
    logic [31:0] m_pval;
    logic [7:0]  m_pen;
    logic        m_pend;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc    <= 0;
            m_val  <= 32'd0;
            m_en   <= 8'hFF;
            m_pval <= 32'd0;
            m_pen  <= 8'd0;
            m_pend <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if ((cyc % FRAME) == FRAME - 1 && m_pend) begin
                m_val <= m_pval;
                m_en  <= m_pen;
            end
            if (bus.load) begin
                m_pval <= bus.value;
                m_pen  <= bus.digit_en;
                m_pend <= 1'b1;
            end else if ((cyc % FRAME) == FRAME - 1 && m_pend) begin
                m_pend <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t cyc=%0d", name, act, exp, $time, cyc);
        end
    endtask

    function automatic logic model_blank(input logic [31:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d != 0) && ((v >> (4 * d)) == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        int          d;
        logic [3:0]  e_nib;
        logic [7:0]  e_ds;
        d     = (cyc / DIGIT) % 8;
        e_nib = 4'((m_val >> (4 * d)) & 32'hF);
        e_ds  = (m_en[d] && !model_blank(m_val, d)) ? ~(8'h01 << d) : 8'hFF;
        chk("model_nibble", {28'd0, bus.nibble}, {28'd0, e_nib});
        chk("model_digitselect", {24'd0, bus.digitselect}, {24'd0, e_ds});
        chk("model_pending", {31'd0, bus.pending}, {31'd0, m_pend});
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Load sampled on posedge number edge_n (counted from 0 after reset release).
    task automatic do_load(input int edge_n, input logic [31:0] v, input logic [7:0] en);
        wait_to(edge_n);
        bus.load     = 1'b1;
        bus.value    = v;
        bus.digit_en = en;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    logic [7:0] walk   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] masked [8] = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'h7F};
    logic [3:0] abcd   [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] lz_a0  [8] = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] lz_0   [8] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    logic [7:0] lz_a0  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] lz_0   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`endif

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        bus.load     = 1'b0;
        bus.value    = 32'd0;
        bus.digit_en = 8'd0;

        repeat (3) @(negedge clk);
        chk("reset_digitselect", {24'd0, bus.digitselect}, 32'hFE);
        chk("reset_nibble", {28'd0, bus.nibble}, 32'h0);
        chk("reset_pending", {31'd0, bus.pending}, 32'h0);
        reset_n = 1'b1;

        for (int d = 0; d < 8; d++) begin
            wait_to(4 * d + 1);
            chk("walk_digitselect", {24'd0, bus.digitselect}, {24'd0, walk[d]});
        end
        wait_to(33);
        chk("walk_wrap", {24'd0, bus.digitselect}, 32'hFE);

        do_load(40, 32'h1234_ABCD, 8'hFF);
        chk("abcd_pending_set", {31'd0, bus.pending}, 32'h1);
        for (int d = 3; d < 8; d++) begin
            wait_to(32 + 4 * d + 1);
            chk("abcd_old_value", {28'd0, bus.nibble}, 32'h0);
        end
        wait_to(64);
        chk("abcd_pending_clear", {31'd0, bus.pending}, 32'h0);
        for (int d = 0; d < 8; d++) begin
            wait_to(64 + 4 * d + 1);
            chk("abcd_nibble", {28'd0, bus.nibble}, {28'd0, abcd[d]});
        end

        do_load(106, 32'h1111_1111, 8'hFF);
        do_load(126, 32'h2222_2222, 8'hFF);
        do_load(127, 32'h3333_3333, 8'hFF);
        chk("dbl_pending_stays", {31'd0, bus.pending}, 32'h1);
        wait_to(129);
        chk("dbl_frame_twos", {28'd0, bus.nibble}, 32'h2);
        wait_to(157);
        chk("dbl_frame_twos_d7", {28'd0, bus.nibble}, 32'h2);
        wait_to(160);
        chk("dbl_pending_clear", {31'd0, bus.pending}, 32'h0);
        wait_to(161);
        chk("dbl_frame_threes", {28'd0, bus.nibble}, 32'h3);

        do_load(170, 32'hFFFF_FFFF, 8'b1010_0101);
        for (int d = 0; d < 8; d++) begin
            wait_to(192 + 4 * d + 1);
            chk("mask_digitselect", {24'd0, bus.digitselect}, {24'd0, masked[d]});
        end

        do_load(230, 32'h5555_5555, 8'hFF);
        wait_to(244);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_digitselect", {24'd0, bus.digitselect}, 32'hFE);
        chk("midreset_pending", {31'd0, bus.pending}, 32'h0);
        chk("midreset_nibble", {28'd0, bus.nibble}, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_to(33);
        chk("postreset_nibble_d0", {28'd0, bus.nibble}, 32'h0);
        wait_to(53);
        chk("postreset_nibble_d5", {28'd0, bus.nibble}, 32'h0);

        do_load(40, 32'h0000_00A0, 8'hFF);
        for (int d = 0; d < 8; d++) begin
            wait_to(64 + 4 * d + 1);
            chk("lz_a0_digitselect", {24'd0, bus.digitselect}, {24'd0, lz_a0[d]});
            if (d == 1) chk("lz_a0_nibble_d1", {28'd0, bus.nibble}, 32'hA);
        end
        do_load(100, 32'h0000_0000, 8'hFF);
        for (int d = 0; d < 8; d++) begin
            wait_to(128 + 4 * d + 1);
            chk("lz_zero_digitselect", {24'd0, bus.digitselect}, {24'd0, lz_0[d]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
